// File: rtl/fetch_pkg.sv
// ==========================================================================
// fetch_pkg : shared constants and state encoding for the fetch stage
// Rev 1.0
// ==========================================================================
`default_nettype none

package fetch_pkg;

   localparam logic [31:0] HALT_INSN_DEF = 32'h0010_0073;
   localparam logic [31:0] BUBBLE_PC     = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ==========================================================================
// fetch_fifo : DEPTH-entry circular buffer of {pc, insn} words
// Rev 1.0
// ==========================================================================
`default_nettype none

module fetch_fifo #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 64,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_rd;

   assign empty   = (r_count == '0);
   assign count   = r_count;
   assign w_rd    = rd_en && !empty;
   // Storage is cleared on reset so the head reads zero while empty after reset.
   assign rd_data = r_mem[r_rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({wr_en, w_rd})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ==========================================================================
// instr_fetch : PC sampling, imem request issue, tagged buffering and halt
// Rev 1.0
// ==========================================================================
`default_nettype none

module instr_fetch
   import fetch_pkg::*;
#(
   parameter int          ADDR_W    = 10,
   parameter int          DEPTH     = 2,
   parameter logic [31:0] HALT_INSN = HALT_INSN_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       pc_in,
   output logic              pc_hold,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instr_out,
   output logic [31:0]       pc_out,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic              finish_flag
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   fetch_state_t     r_state;
   fetch_state_t     w_state_nxt;
   logic             r_inflight;
   logic [31:0]      r_tag;
   logic [CNT_W-1:0] w_count;
   logic             w_empty;
   logic [CNT_W:0]   w_used;
   logic             w_can_issue;
   logic             w_halt_now;
   logic             w_issue;
   logic             w_pop;
   logic [63:0]      w_head;

   assign imem_addr = pc_in[ADDR_W-1:0];

   // Credits count the in-flight return too; a same-cycle pop frees nothing.
   assign w_used      = {1'b0, w_count} + (CNT_W + 1)'(r_inflight);
   assign w_can_issue = w_used < (CNT_W + 1)'(DEPTH);
   assign w_halt_now  = r_inflight && (imem_rdata == HALT_INSN);
   assign w_issue     = !pc_hold && (pc_in != BUBBLE_PC);
   assign instr_valid = !w_empty;
   assign w_pop       = instr_valid && instr_ready;
   assign instr_out   = w_head[31:0];
   assign pc_out      = w_head[63:32];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_inflight <= 1'b0;
         r_tag      <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_tag <= pc_in;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // The halt word is the youngest entry, so an emptying pop in DRAIN consumes it.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN:     if (w_halt_now) w_state_nxt = DRAIN;
         DRAIN:   if (w_pop && (w_count == CNT_W'(1))) w_state_nxt = DONE;
         DONE:    w_state_nxt = DONE;
         default: w_state_nxt = RUN;
      endcase
   end

   always_comb begin
      pc_hold     = (r_state != RUN) || w_halt_now || !w_can_issue;
      finish_flag = (r_state == DONE);
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (64)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (r_inflight),
      .wr_data ({r_tag, imem_rdata}),
      .rd_en   (w_pop),
      .rd_data (w_head),
      .count   (w_count),
      .empty   (w_empty)
   );

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ==========================================================================
// tb_instr_fetch : directed bench for instr_fetch with a 4-entry buffer
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_instr_fetch;

   localparam logic [31:0] HALT = 32'h0010_0073;
   localparam logic [31:0] BUB  = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_in;
   logic        pc_hold;
   logic [9:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        instr_valid;
   logic        instr_ready;
   logic        finish_flag;

   logic [31:0] imem [1024];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) imem_rdata <= imem[imem_addr];

   instr_fetch #(
      .ADDR_W    (10),
      .DEPTH     (4),
      .HALT_INSN (HALT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pc_in       (pc_in),
      .pc_hold     (pc_hold),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .instr_out   (instr_out),
      .pc_out      (pc_out),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .finish_flag (finish_flag)
   );

   typedef struct {
      logic [31:0] pc;
      logic        rdy;
      logic        valid;
      logic        chk;
      logic [31:0] instr;
      logic [31:0] tag;
      logic        hold;
      logic [9:0]  addr;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      pc_in       = BUB;
      instr_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // PC model: advances by one at each edge unless hold was seen before it.
   task automatic cycle_pc();
      logic h;
      h = pc_hold;
      @(posedge clk);
      #1;
      if (!h) pc_in = pc_in + 32'd1;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      int halt_cyc;
      int first_hold;

      for (int i = 0; i < 1024; i++) imem[i] = 32'h13 + i;

      //            pc            rdy   valid chk   instr        tag          hold  addr
      vecs[0]  = '{BUB,          1'b1, 1'b0, 1'b1, 32'h0,       32'h0,       1'b0, 10'h3FF};
      vecs[1]  = '{32'h0,        1'b1, 1'b0, 1'b1, 32'h0,       32'h0,       1'b0, 10'h000};
      vecs[2]  = '{32'h1,        1'b1, 1'b0, 1'b0, 32'h0,       32'h0,       1'b0, 10'h001};
      vecs[3]  = '{32'h2,        1'b1, 1'b1, 1'b1, 32'h13,      32'h0,       1'b0, 10'h002};
      vecs[4]  = '{32'h3,        1'b1, 1'b1, 1'b1, 32'h14,      32'h1,       1'b0, 10'h003};
      vecs[5]  = '{BUB,          1'b1, 1'b1, 1'b1, 32'h15,      32'h2,       1'b0, 10'h3FF};
      vecs[6]  = '{BUB,          1'b1, 1'b1, 1'b1, 32'h16,      32'h3,       1'b0, 10'h3FF};
      vecs[7]  = '{BUB,          1'b1, 1'b0, 1'b0, 32'h0,       32'h0,       1'b0, 10'h3FF};
      vecs[8]  = '{32'h405,      1'b1, 1'b0, 1'b0, 32'h0,       32'h0,       1'b0, 10'h005};
      vecs[9]  = '{BUB,          1'b1, 1'b0, 1'b0, 32'h0,       32'h0,       1'b0, 10'h3FF};
      vecs[10] = '{BUB,          1'b0, 1'b1, 1'b1, 32'h18,      32'h405,     1'b0, 10'h3FF};
      vecs[11] = '{BUB,          1'b1, 1'b1, 1'b1, 32'h18,      32'h405,     1'b0, 10'h3FF};
      vecs[12] = '{BUB,          1'b1, 1'b0, 1'b0, 32'h0,       32'h0,       1'b0, 10'h3FF};

      // Startup latency, bubbles, backpressure on one word, address wrap.
      do_reset();
      for (int i = 0; i < 13; i++) begin
         pc_in       = vecs[i].pc;
         instr_ready = vecs[i].rdy;
         @(negedge clk);
         check($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].valid));
         check($sformatf("v%0d_hold", i), 32'(pc_hold), 32'(vecs[i].hold));
         check($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vecs[i].addr));
         if (vecs[i].chk) begin
            check($sformatf("v%0d_instr", i), instr_out, vecs[i].instr);
            check($sformatf("v%0d_tag", i), pc_out, vecs[i].tag);
         end
         if (i == 0) check("reset_finish", 32'(finish_flag), 32'h0);
         @(posedge clk);
         #1;
      end

      // Backpressure from start: hold after four issues, then ordered drain.
      do_reset();
      @(negedge clk);
      first_hold = -1;
      for (int c = 0; c < 10; c++) begin
         if (pc_hold && first_hold < 0) first_hold = c;
         cycle_pc();
      end
      check("bp_first_hold", 32'(first_hold), 32'd5);
      check("bp_pc_frozen", pc_in, 32'd4);
      check("bp_hold", 32'(pc_hold), 32'h1);
      check("bp_head_tag", pc_out, 32'd0);
      instr_ready = 1'b1;
      n = 0;
      for (int c = 0; c < 20 && n < 6; c++) begin
         if (instr_valid) begin
            check($sformatf("bp_tag%0d", n), pc_out, 32'(n));
            check($sformatf("bp_instr%0d", n), instr_out, 32'h13 + 32'(n));
            n++;
         end
         cycle_pc();
      end
      check("bp_pop_count", 32'(n), 32'd6);

      // Asynchronous reset mid-cycle with a return pending.
      do_reset();
      @(negedge clk);
      for (int c = 0; c < 5; c++) cycle_pc();
      check("rst_pre_valid", 32'(instr_valid), 32'h1);
      reset = 1'b1;
      #2;
      check("rst_valid", 32'(instr_valid), 32'h0);
      check("rst_instr", instr_out, 32'h0);
      check("rst_tag", pc_out, 32'h0);
      check("rst_hold", 32'(pc_hold), 32'h0);
      #2;
      reset = 1'b0;
      pc_in = BUB;
      instr_ready = 1'b1;
      @(negedge clk);
      check("rst_drop0", 32'(instr_valid), 32'h0);
      cycle_pc();
      check("rst_drop1", 32'(instr_valid), 32'h0);
      n = 0;
      for (int c = 0; c < 10 && n == 0; c++) begin
         if (instr_valid) begin
            check("rst_restart_tag", pc_out, 32'd0);
            check("rst_restart_instr", instr_out, 32'h13);
            n = 1;
         end
         cycle_pc();
      end
      check("rst_restart_seen", 32'(n), 32'd1);

      // Steady stream: one word per cycle, never held.
      do_reset();
      instr_ready = 1'b1;
      @(negedge clk);
      for (int c = 0; c < 25; c++) begin
         check($sformatf("st_hold%0d", c), 32'(pc_hold), 32'h0);
         if (c >= 3) begin
            check($sformatf("st_valid%0d", c), 32'(instr_valid), 32'h1);
            check($sformatf("st_tag%0d", c), pc_out, 32'(c - 3));
            check($sformatf("st_instr%0d", c), instr_out, 32'h13 + 32'(c - 3));
         end
         cycle_pc();
      end

      // Halt: words 0..3 delivered, fetch stops at pc 4, finish after last pop.
      imem[3] = HALT;
      do_reset();
      instr_ready = 1'b1;
      @(negedge clk);
      n = 0;
      halt_cyc = -1;
      for (int c = 0; c < 15; c++) begin
         if (halt_cyc >= 0 && c == halt_cyc + 1) begin
            check("halt_finish_rise", 32'(finish_flag), 32'h1);
            check("halt_drained", 32'(instr_valid), 32'h0);
         end
         if (instr_valid) begin
            check($sformatf("halt_tag%0d", n), pc_out, 32'(n));
            check($sformatf("halt_instr%0d", n), instr_out, (n == 3) ? HALT : 32'h13 + 32'(n));
            if (pc_out == 32'd3) begin
               halt_cyc = c;
               check("halt_finish_early", 32'(finish_flag), 32'h0);
            end
            n++;
         end
         cycle_pc();
      end
      check("halt_pops", 32'(n), 32'd4);
      check("halt_cycle", 32'(halt_cyc), 32'd6);
      check("halt_pc_stuck", pc_in, 32'd4);
      check("halt_hold", 32'(pc_hold), 32'h1);
      check("halt_finish", 32'(finish_flag), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
